sdram_arbiter: RTL and testbench
================================

Name: sdram_arbiter

Overview:
Owns the shared SDRAM command/address/DQ bus after power-up and grants it to one sub-controller at a time: sdram_init, sdram_aref, sdram_write and sdram_read.
- Sits between those sub-controllers and the SDRAM pins.
- Holds off all traffic until init_end.
- Arbitrates with priority refresh > write > read.
- Drives each sub-controller's enable and returns the bus on its end pulse.

Parameters:
ADDR_W, 13, SDRAM row/column address width
BANK_W, 2, bank address width
DQ_W, 16, data bus width

Ports:
arb_clk  input  1  single clock; all logic on rising edge
arb_rst  input  1  synchronous, active-high reset
init_end  input  1  level, high once sdram_init finished
init_cmd  input  4  {cs_n,ras_n,cas_n,we_n} from sdram_init
init_bank  input  BANK_W  bank from sdram_init
init_addr  input  ADDR_W  address from sdram_init
aref_req  input  1  refresh request, held until served
aref_end  input  1  one-cycle pulse, refresh sequence done
aref_cmd  input  4  command from sdram_aref
aref_addr  input  ADDR_W  address from sdram_aref (A10=1 for precharge-all)
aref_en  output  1  refresh grant
wr_req  input  1  write request, held until served
wr_end  input  1  one-cycle pulse, burst write done
wr_sdram_cmd  input  4  command from sdram_write
wr_sdram_bank  input  BANK_W  bank from sdram_write
wr_sdram_addr  input  ADDR_W  address from sdram_write
wr_sdram_en  input  1  sdram_write drives DQ
wr_sdram_data  input  DQ_W  write data
wr_en  output  1  write grant
rd_req  input  1  read request, held until served
rd_end  input  1  one-cycle pulse, burst read done
rd_sdram_cmd  input  4  command from sdram_read
rd_sdram_bank  input  BANK_W  bank from sdram_read
rd_sdram_addr  input  ADDR_W  address from sdram_read
rd_en  output  1  read grant
sdram_cmd  output  4  muxed command to pins
sdram_bank  output  BANK_W  muxed bank
sdram_addr  output  ADDR_W  muxed address
sdram_dq_out  output  DQ_W  write data to pad
sdram_dq_oe  output  1  DQ output enable

Behaviour:
- States: IDLE, ARB, AREF, WRITE, READ; registered state, next-state combinational.
- Reset (arb_rst=1 at clock edge): state=IDLE; aref_en=wr_en=rd_en=0. Effective from the first edge with arb_rst high, including mid-burst. The abandoned sub-controller is reset by the same signal.
- IDLE:
  - bus = init_cmd/init_bank/init_addr.
  - init_end=1 -> ARB next cycle.
  - init_end is sampled only in IDLE.
- ARB:
  - sdram_cmd = NOP 4'b0111; bank = 0; addr = 0.
  - Decision on the same edge that leaves ARB:
    - aref_req -> AREF, aref_en<=1
    - else wr_req -> WRITE, wr_en<=1
    - else rd_req -> READ, rd_en<=1
    - else stay in ARB.
  - Grant latency: request seen high in ARB -> enable high on the next edge.
- AREF / WRITE / READ:
  - bus = that sub-controller's cmd/bank/addr. sdram_bank = 0 in AREF.
  - The enable stays high regardless of request deassertion.
  - On the matching end pulse: enable<=0 and state<=ARB on the same edge.
  - The next grant is earliest 2 cycles after the end pulse, giving one NOP cycle between sequences.
- Preemption and ignored inputs:
  - No preemption. aref_req raised during WRITE/READ waits for the end pulse, then wins in ARB.
  - End pulses for non-granted sub-controllers are ignored.
  - Requests during IDLE are ignored (not latched; sub-controllers hold them).
- Simultaneous requests: all three high in ARB -> AREF; write and read high -> WRITE (fixed priority, see Optional Feature).
- DQ: sdram_dq_oe = wr_sdram_en when state==WRITE, else 0. sdram_dq_out = wr_sdram_data, passthrough.
- At most one of aref_en/wr_en/rd_en is high at any time. The bench asserts this.
- Bus mux is combinational on registered state. All enables are registered.

Optional Feature:
Macro ARB_ROUND_ROBIN_EN.
- Defined:
  - 1-bit last_rw register, reset 0 = write. Set to 0 when WRITE is entered, 1 when READ is entered.
  - When wr_req and rd_req are both high in ARB (no aref_req), grant the one not equal to last_rw.
  - Refresh still has absolute priority.
- Undefined: fixed write>read; last_rw absent.

Decomposition:
- Shared header (alongside Config-AC.v): CMD_NOP=4'b0111 and arbiter state encodings ARB_IDLE=3'b000, ARB_ARB=3'b001, ARB_AREF=3'b011, ARB_WRITE=3'b010, ARB_READ=3'b110. The bench decodes state names from these encodings.
- One sub-module is natural: sdram_cmd_mux, a purely combinational state-indexed select of cmd/bank/addr. It is also reusable by the top-level controller.

Test Plan:
- Reset 10 cycles, release; init completes -> sdram_cmd follows init_cmd until init_end, then NOP, no enables while wr_req=0/rd_req=0.
- After init, wr_req=1 (sdram_write, 24'h000000, burst 10) -> wr_en high 1 cycle after ARB; ACT/WR commands and DQ values 0..9 on pins with sdram_dq_oe=1; wr_en low on wr_end; model reports 10 writes.
- aref_req raised mid-write burst -> no AREF command until wr_end; then NOP, aref_en=1, refresh commands issued; rd_req held meanwhile is granted only after aref_end.
- wr_req, rd_req, aref_req all rise same cycle in ARB -> grant order AREF, WRITE, READ, each separated by one NOP cycle; enables never overlap.
- With ARB_ROUND_ROBIN_EN: wr_req and rd_req held continuously -> grants alternate WRITE, READ, WRITE, READ; without the macro, WRITE every time.
- arb_rst asserted during READ -> next edge all enables 0, state IDLE, bus follows init_cmd; after re-init, traffic resumes normally.

Source files
------------

// File: rtl/sdram_arbiter_pkg.sv
// Shared constants for the SDRAM bus arbiter: NOP command and arbiter state encodings.
package sdram_arbiter_pkg;

    localparam logic [3:0] CMD_NOP = 4'b0111;

    typedef enum logic [2:0] {
        ARB_IDLE  = 3'b000,
        ARB_ARB   = 3'b001,
        ARB_AREF  = 3'b011,
        ARB_WRITE = 3'b010,
        ARB_READ  = 3'b110
    } arb_state_t;

endpackage

// File: rtl/sdram_cmd_mux.sv
// State-indexed select of the SDRAM command/bank/address from the owning sub-controller.
module sdram_cmd_mux
    import sdram_arbiter_pkg::*;
#(
    parameter int ADDR_W = 13,
    parameter int BANK_W = 2
) (
    input  arb_state_t        state,
    input  logic [3:0]        init_cmd,
    input  logic [BANK_W-1:0] init_bank,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic [3:0]        aref_cmd,
    input  logic [ADDR_W-1:0] aref_addr,
    input  logic [3:0]        wr_cmd,
    input  logic [BANK_W-1:0] wr_bank,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [3:0]        rd_cmd,
    input  logic [BANK_W-1:0] rd_bank,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [3:0]        cmd,
    output logic [BANK_W-1:0] bank,
    output logic [ADDR_W-1:0] addr
);

    always_comb begin
        cmd  = CMD_NOP;
        bank = '0;
        addr = '0;
        case (state)
            ARB_IDLE: begin
                cmd  = init_cmd;
                bank = init_bank;
                addr = init_addr;
            end
            // refresh is all-bank, so the bank lines stay at zero
            ARB_AREF: begin
                cmd  = aref_cmd;
                addr = aref_addr;
            end
            ARB_WRITE: begin
                cmd  = wr_cmd;
                bank = wr_bank;
                addr = wr_addr;
            end
            ARB_READ: begin
                cmd  = rd_cmd;
                bank = rd_bank;
                addr = rd_addr;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/sdram_arbiter.sv
// SDRAM bus arbiter: init owns the bus until init_end, then refresh > write > read.
// Optional ARB_ROUND_ROBIN_EN alternates write/read when both are pending.
module sdram_arbiter
    import sdram_arbiter_pkg::*;
#(
    parameter int ADDR_W = 13,
    parameter int BANK_W = 2,
    parameter int DQ_W   = 16
) (
    input  logic              arb_clk,
    input  logic              arb_rst,
    input  logic              init_end,
    input  logic [3:0]        init_cmd,
    input  logic [BANK_W-1:0] init_bank,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic              aref_req,
    input  logic              aref_end,
    input  logic [3:0]        aref_cmd,
    input  logic [ADDR_W-1:0] aref_addr,
    output logic              aref_en,
    input  logic              wr_req,
    input  logic              wr_end,
    input  logic [3:0]        wr_sdram_cmd,
    input  logic [BANK_W-1:0] wr_sdram_bank,
    input  logic [ADDR_W-1:0] wr_sdram_addr,
    input  logic              wr_sdram_en,
    input  logic [DQ_W-1:0]   wr_sdram_data,
    output logic              wr_en,
    input  logic              rd_req,
    input  logic              rd_end,
    input  logic [3:0]        rd_sdram_cmd,
    input  logic [BANK_W-1:0] rd_sdram_bank,
    input  logic [ADDR_W-1:0] rd_sdram_addr,
    output logic              rd_en,
    output logic [3:0]        sdram_cmd,
    output logic [BANK_W-1:0] sdram_bank,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic [DQ_W-1:0]   sdram_dq_out,
    output logic              sdram_dq_oe
);

    arb_state_t state_q, state_d;
    logic       rd_wins;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_rw;  // 0: write was granted last, 1: read was

    assign rd_wins = rd_req && (!wr_req || !last_rw);

    always_ff @(posedge arb_clk) begin
        if (arb_rst)
            last_rw <= 1'b0;
        else if (state_q == ARB_ARB && state_d == ARB_WRITE)
            last_rw <= 1'b0;
        else if (state_q == ARB_ARB && state_d == ARB_READ)
            last_rw <= 1'b1;
    end
`else
    assign rd_wins = rd_req && !wr_req;
`endif

    always_ff @(posedge arb_clk) begin
        if (arb_rst)
            state_q <= ARB_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE:  if (init_end) state_d = ARB_ARB;
            ARB_ARB: begin
                if (aref_req)     state_d = ARB_AREF;
                else if (rd_wins) state_d = ARB_READ;
                else if (wr_req)  state_d = ARB_WRITE;
            end
            ARB_AREF:  if (aref_end) state_d = ARB_ARB;
            ARB_WRITE: if (wr_end)   state_d = ARB_ARB;
            ARB_READ:  if (rd_end)   state_d = ARB_ARB;
            default:   state_d = ARB_IDLE;
        endcase
    end

    // Enables track the next state so a grant lands on the edge that leaves ARB
    always_ff @(posedge arb_clk) begin
        if (arb_rst) begin
            aref_en <= 1'b0;
            wr_en   <= 1'b0;
            rd_en   <= 1'b0;
        end else begin
            aref_en <= (state_d == ARB_AREF);
            wr_en   <= (state_d == ARB_WRITE);
            rd_en   <= (state_d == ARB_READ);
        end
    end

    sdram_cmd_mux #(.ADDR_W(ADDR_W), .BANK_W(BANK_W)) u_cmd_mux (
        .state     (state_q),
        .init_cmd  (init_cmd),
        .init_bank (init_bank),
        .init_addr (init_addr),
        .aref_cmd  (aref_cmd),
        .aref_addr (aref_addr),
        .wr_cmd    (wr_sdram_cmd),
        .wr_bank   (wr_sdram_bank),
        .wr_addr   (wr_sdram_addr),
        .rd_cmd    (rd_sdram_cmd),
        .rd_bank   (rd_sdram_bank),
        .rd_addr   (rd_sdram_addr),
        .cmd       (sdram_cmd),
        .bank      (sdram_bank),
        .addr      (sdram_addr)
    );

    assign sdram_dq_out = wr_sdram_data;
    assign sdram_dq_oe  = (state_q == ARB_WRITE) && wr_sdram_en;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: directed vector table, multi-cycle sequences, randomized model check.
module tb_sdram_arbiter;
    import sdram_arbiter_pkg::*;

    localparam int AW = 13;
    localparam int BW = 2;
    localparam int DW = 16;

    // bus owner codes used by the bench: 0 init, 1 free (NOP), 2 refresh, 3 write, 4 read
    localparam int O_INIT = 0, O_FREE = 1, O_AREF = 2, O_WR = 3, O_RD = 4;

    logic          arb_clk = 1'b0;
    logic          arb_rst, init_end;
    logic [3:0]    init_cmd;
    logic [BW-1:0] init_bank;
    logic [AW-1:0] init_addr;
    logic          aref_req, aref_end, aref_en;
    logic [3:0]    aref_cmd;
    logic [AW-1:0] aref_addr;
    logic          wr_req, wr_end, wr_en, wr_sdram_en;
    logic [3:0]    wr_sdram_cmd;
    logic [BW-1:0] wr_sdram_bank;
    logic [AW-1:0] wr_sdram_addr;
    logic [DW-1:0] wr_sdram_data;
    logic          rd_req, rd_end, rd_en;
    logic [3:0]    rd_sdram_cmd;
    logic [BW-1:0] rd_sdram_bank;
    logic [AW-1:0] rd_sdram_addr;
    logic [3:0]    sdram_cmd;
    logic [BW-1:0] sdram_bank;
    logic [AW-1:0] sdram_addr;
    logic [DW-1:0] sdram_dq_out;
    logic          sdram_dq_oe;

    always #5 arb_clk = ~arb_clk;

    sdram_arbiter #(.ADDR_W(AW), .BANK_W(BW), .DQ_W(DW)) dut (
        .arb_clk(arb_clk), .arb_rst(arb_rst), .init_end(init_end),
        .init_cmd(init_cmd), .init_bank(init_bank), .init_addr(init_addr),
        .aref_req(aref_req), .aref_end(aref_end), .aref_cmd(aref_cmd),
        .aref_addr(aref_addr), .aref_en(aref_en),
        .wr_req(wr_req), .wr_end(wr_end), .wr_sdram_cmd(wr_sdram_cmd),
        .wr_sdram_bank(wr_sdram_bank), .wr_sdram_addr(wr_sdram_addr),
        .wr_sdram_en(wr_sdram_en), .wr_sdram_data(wr_sdram_data), .wr_en(wr_en),
        .rd_req(rd_req), .rd_end(rd_end), .rd_sdram_cmd(rd_sdram_cmd),
        .rd_sdram_bank(rd_sdram_bank), .rd_sdram_addr(rd_sdram_addr), .rd_en(rd_en),
        .sdram_cmd(sdram_cmd), .sdram_bank(sdram_bank), .sdram_addr(sdram_addr),
        .sdram_dq_out(sdram_dq_out), .sdram_dq_oe(sdram_dq_oe)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // grants must never overlap
    always @(negedge arb_clk)
        chk("en_exclusive", 32'($countones({aref_en, wr_en, rd_en}) <= 1), 32'd1);

    function automatic logic [2:0] state_of(input int o);
        case (o)
            O_INIT:  return ARB_IDLE;
            O_FREE:  return ARB_ARB;
            O_AREF:  return ARB_AREF;
            O_WR:    return ARB_WRITE;
            default: return ARB_READ;
        endcase
    endfunction

    task automatic chk_bus(input string tag, input int o);
        logic [3:0]    ec;
        logic [BW-1:0] eb;
        logic [AW-1:0] ea;
        case (o)
            O_INIT:  begin ec = init_cmd;     eb = init_bank;     ea = init_addr;     end
            O_FREE:  begin ec = CMD_NOP;      eb = '0;            ea = '0;            end
            O_AREF:  begin ec = aref_cmd;     eb = '0;            ea = aref_addr;     end
            O_WR:    begin ec = wr_sdram_cmd; eb = wr_sdram_bank; ea = wr_sdram_addr; end
            default: begin ec = rd_sdram_cmd; eb = rd_sdram_bank; ea = rd_sdram_addr; end
        endcase
        chk({tag, ".cmd"},   sdram_cmd,  ec);
        chk({tag, ".bank"},  sdram_bank, eb);
        chk({tag, ".addr"},  sdram_addr, ea);
        chk({tag, ".en"},    {aref_en, wr_en, rd_en}, {o == O_AREF, o == O_WR, o == O_RD});
        chk({tag, ".oe"},    sdram_dq_oe, (o == O_WR) && wr_sdram_en);
        chk({tag, ".dq"},    sdram_dq_out, wr_sdram_data);
        chk({tag, ".state"}, dut.state_q, state_of(o));
    endtask

    task automatic tick();
        @(posedge arb_clk);
        #1;
    endtask

    typedef struct {
        logic rst, ie, ar, wr, rd, ae, we, re;
        int   owner;   // expected bus owner after the edge
    } vec_t;

    task automatic set_ctl(input vec_t v);
        arb_rst  = v.rst; init_end = v.ie;
        aref_req = v.ar;  wr_req   = v.wr; rd_req = v.rd;
        aref_end = v.ae;  wr_end   = v.we; rd_end = v.re;
    endtask

    function automatic vec_t mk(input logic [7:0] c, input int o);
        vec_t v;
        {v.rst, v.ie, v.ar, v.wr, v.rd, v.ae, v.we, v.re} = c;
        v.owner = o;
        return v;
    endfunction

    // reference model: who owns the bus after the next edge
    int m_owner;
    bit m_last_rd;

    function automatic int model_next(input int o);
        if (arb_rst) return O_INIT;
        case (o)
            O_INIT: return init_end ? O_FREE : O_INIT;
            O_FREE: begin
                if (aref_req) return O_AREF;
                if (wr_req && rd_req) begin
`ifdef ARB_ROUND_ROBIN_EN
                    return m_last_rd ? O_WR : O_RD;
`else
                    return O_WR;
`endif
                end
                if (wr_req) return O_WR;
                if (rd_req) return O_RD;
                return O_FREE;
            end
            O_AREF:  return aref_end ? O_FREE : O_AREF;
            O_WR:    return wr_end   ? O_FREE : O_WR;
            default: return rd_end   ? O_FREE : O_RD;
        endcase
    endfunction

    vec_t tbl[24];

    initial begin
        //              rst ie ar wr rd ae we re
        tbl[0]  = mk(8'b1000_0000, O_INIT);
        tbl[1]  = mk(8'b1001_0000, O_INIT);  // request during reset
        tbl[2]  = mk(8'b0001_0000, O_INIT);  // request ignored before init_end
        tbl[3]  = mk(8'b0101_0000, O_FREE);
        tbl[4]  = mk(8'b0101_0000, O_WR);
        tbl[5]  = mk(8'b0010_0000, O_WR);    // req dropped, refresh waits
        tbl[6]  = mk(8'b0010_0101, O_WR);    // foreign end pulses ignored
        tbl[7]  = mk(8'b0010_0010, O_FREE);
        tbl[8]  = mk(8'b0010_1000, O_AREF);
        tbl[9]  = mk(8'b0000_1000, O_AREF);
        tbl[10] = mk(8'b0000_1100, O_FREE);
        tbl[11] = mk(8'b0000_1000, O_RD);
        tbl[12] = mk(8'b0000_0001, O_FREE);
        tbl[13] = mk(8'b0011_1000, O_AREF);  // all three at once
        tbl[14] = mk(8'b0001_1100, O_FREE);
        tbl[15] = mk(8'b0001_1000, O_WR);
        tbl[16] = mk(8'b0000_1010, O_FREE);
        tbl[17] = mk(8'b0000_1000, O_RD);
        tbl[18] = mk(8'b1000_1000, O_INIT);  // reset mid-read
        tbl[19] = mk(8'b0000_1000, O_INIT);
        tbl[20] = mk(8'b0100_1000, O_FREE);
        tbl[21] = mk(8'b0000_1000, O_RD);
        tbl[22] = mk(8'b0000_0001, O_FREE);
        tbl[23] = mk(8'b0000_0000, O_FREE);

        init_cmd = 4'h1; init_bank = 2'd1; init_addr = 13'h101;
        aref_cmd = 4'h2; aref_addr = 13'h400;
        wr_sdram_cmd = 4'h3; wr_sdram_bank = 2'd2; wr_sdram_addr = 13'h123;
        rd_sdram_cmd = 4'h4; rd_sdram_bank = 2'd3; rd_sdram_addr = 13'h456;
        wr_sdram_en = 1'b1; wr_sdram_data = 16'hbeef;

        set_ctl(mk(8'b1000_0000, O_INIT));
        repeat (10) tick();
        chk_bus("reset", O_INIT);

        foreach (tbl[i]) begin
            set_ctl(tbl[i]);
            tick();
            chk_bus($sformatf("vec%0d", i), tbl[i].owner);
        end
        set_ctl(mk(8'b0000_0000, O_FREE));

        // write and read held continuously; read was granted last
        wr_req = 1'b1; rd_req = 1'b1;
        for (int g = 0; g < 4; g++) begin
            int w;
            int got;
            int expg;
            w = 0;
            do begin
                tick();
                w++;
            end while (!(wr_en || rd_en) && w < 8);
            got = wr_en ? O_WR : (rd_en ? O_RD : O_FREE);
`ifdef ARB_ROUND_ROBIN_EN
            expg = (g % 2 == 0) ? O_WR : O_RD;
`else
            expg = O_WR;
`endif
            chk($sformatf("rr_grant%0d", g), got, expg);
            chk($sformatf("rr_latency%0d", g), w, 1);
            tick();
            wr_end = (got == O_WR);
            rd_end = (got == O_RD);
            tick();
            wr_end = 1'b0; rd_end = 1'b0;
            chk_bus($sformatf("rr_gap%0d", g), O_FREE);
        end
        wr_req = 1'b0; rd_req = 1'b0;
        tick();

        // burst of ten writes, data passes straight to the pads
        wr_req = 1'b1;
        tick();
        wr_req = 1'b0;
        chk_bus("burst_grant", O_WR);
        for (int i = 0; i < 10; i++) begin
            wr_sdram_data = 16'(i);
            #1;
            chk($sformatf("burst_dq%0d", i), sdram_dq_out, i);
            chk($sformatf("burst_oe%0d", i), sdram_dq_oe, 1'b1);
            tick();
        end
        wr_end = 1'b1;
        tick();
        wr_end = 1'b0;
        chk_bus("burst_done", O_FREE);

        // randomized traffic against the model
        arb_rst = 1'b1;
        tick();
        m_owner = O_INIT;
        m_last_rd = 1'b0;
        chk_bus("rnd_reset", O_INIT);
        for (int c = 0; c < 1500; c++) begin
            int nxt;
            arb_rst  = ($urandom_range(99) == 0);
            init_end = $urandom_range(1);
            aref_req = ($urandom_range(3) == 0);
            wr_req   = $urandom_range(1);
            rd_req   = $urandom_range(1);
            aref_end = ($urandom_range(3) == 0);
            wr_end   = ($urandom_range(3) == 0);
            rd_end   = ($urandom_range(3) == 0);
            init_cmd = 4'($urandom); init_bank = 2'($urandom); init_addr = 13'($urandom);
            aref_cmd = 4'($urandom); aref_addr = 13'($urandom);
            wr_sdram_cmd = 4'($urandom); wr_sdram_bank = 2'($urandom);
            wr_sdram_addr = 13'($urandom); wr_sdram_en = $urandom_range(1);
            wr_sdram_data = 16'($urandom);
            rd_sdram_cmd = 4'($urandom); rd_sdram_bank = 2'($urandom);
            rd_sdram_addr = 13'($urandom);
            nxt = model_next(m_owner);
            if (arb_rst) m_last_rd = 1'b0;
            else if (m_owner == O_FREE && nxt == O_WR) m_last_rd = 1'b0;
            else if (m_owner == O_FREE && nxt == O_RD) m_last_rd = 1'b1;
            m_owner = nxt;
            tick();
            chk_bus($sformatf("rnd%0d", c), m_owner);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
